// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ARM-style ALU with iterative multiply and
// unsigned divide/modulo behind a Start/Busy/Done handshake.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  input  logic             C_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_EOR  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_RSB  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_SBC  = 4'b0110;
  localparam logic [3:0] OP_RSC  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_UDIV = 4'b1001;
  localparam logic [3:0] OP_UMOD = 4'b1010;
  localparam logic [3:0] OP_RSV  = 4'b1011;
  localparam logic [3:0] OP_ORR  = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_BIC  = 4'b1110;
  localparam logic [3:0] OP_MVN  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  // Single-cycle datapath: one shared WIDTH+1-bit adder X + Y + cin
  logic [WIDTH-1:0] add_x, add_y, logic_res;
  logic             add_c, is_arith;
  logic [WIDTH:0]   sum;

  always_comb begin
    add_x     = Src_A;
    add_y     = Src_B;
    add_c     = 1'b0;
    is_arith  = 1'b1;
    logic_res = '0;
    unique case (ALUControl)
      OP_AND: begin
        is_arith  = 1'b0;
        logic_res = Src_A & Src_B;
      end
      OP_EOR: begin
        is_arith  = 1'b0;
        logic_res = Src_A ^ Src_B;
      end
      OP_SUB: begin
        add_y = ~Src_B;
        add_c = 1'b1;
      end
      OP_RSB: begin
        add_x = Src_B;
        add_y = ~Src_A;
        add_c = 1'b1;
      end
      OP_ADD: begin
        add_c = 1'b0;
      end
      OP_ADC: begin
        add_c = C_in;
      end
      OP_SBC: begin
        add_y = ~Src_B;
        add_c = C_in;
      end
      OP_RSC: begin
        add_x = Src_B;
        add_y = ~Src_A;
        add_c = C_in;
      end
      OP_MUL, OP_UDIV, OP_UMOD, OP_RSV: begin
        is_arith = 1'b0;
      end
      OP_ORR: begin
        is_arith  = 1'b0;
        logic_res = Src_A | Src_B;
      end
      OP_MOV: begin
        is_arith  = 1'b0;
        logic_res = Src_B;
      end
      OP_BIC: begin
        is_arith  = 1'b0;
        logic_res = Src_A & ~Src_B;
      end
      OP_MVN: begin
        is_arith  = 1'b0;
        logic_res = ~Src_B;
      end
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y}
             + {{WIDTH{1'b0}}, add_c};

  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_v;

  assign alu_res = is_arith ? sum[WIDTH-1:0] : logic_res;
  assign alu_v   = is_arith
                 && (add_x[WIDTH-1] == add_y[WIDTH-1])
                 && (sum[WIDTH-1] != add_x[WIDTH-1]);
  assign alu_flags = {alu_res[WIDTH-1], alu_res == '0,
                      is_arith ? sum[WIDTH] : C_in, alu_v};

  // Iteration datapaths: shift-add multiply and restoring divide
  logic [WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  assign mul_nxt   = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, dvs_q};
  // Partial remainder stays below the divisor, so WIDTH bits suffice
  assign rem_nxt   = div_ge ? div_shift[WIDTH-1:0] - dvs_q
                            : div_shift[WIDTH-1:0];
  assign quo_nxt   = {quo_q[WIDTH-2:0], div_ge};

  logic start_mul, start_div;
  logic fin;
  logic [WIDTH-1:0] fin_val;

  assign start_mul = ALUControl == OP_MUL;
  assign start_div = (ALUControl == OP_UDIV) || (ALUControl == OP_UMOD);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    cin_d    = cin_q;
    dz_d     = dz_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    fin      = 1'b0;
    fin_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d  = ALUControl;
          cin_d = C_in;
          cnt_d = '0;
          unique case (1'b1)
            start_mul: begin
              state_d  = S_MUL;
              acc_d    = '0;
              mcand_d  = Src_A;
              mplier_d = Src_B;
            end
            start_div: begin
              state_d = S_DIV;
              rem_d   = '0;
              quo_d   = Src_A;
              dvs_d   = Src_B;
              dz_d    = Src_B == '0;
            end
            default: begin
              result_d = alu_res;
              flags_d  = alu_flags;
              done_d   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d    = mul_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          fin     = 1'b1;
          fin_val = mul_nxt;
        end
      end
      S_DIV: begin
        if (dz_q) begin
          // Divide by zero: quotient 0, remainder is the dividend
          fin     = 1'b1;
          fin_val = (op_q == OP_UMOD) ? quo_q : '0;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            fin     = 1'b1;
            fin_val = (op_q == OP_UMOD) ? rem_nxt : quo_nxt;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (fin) begin
      result_d = fin_val;
      flags_d  = {fin_val[WIDTH-1], fin_val == '0, cin_q, 1'b0};
      done_d   = 1'b1;
      state_d  = S_IDLE;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      dz_q     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      dz_q     <= dz_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign Busy     = state_q != S_IDLE;
  assign Done     = done_q;
  assign Result   = result_q;
  assign ALUFlags = flags_q;

endmodule
